// File: rtl/chess_key_conditioner_pkg.sv
// Shared definitions for the chess key front end: key polarity, key codes,
// conditioner FSM state encoding and small combinational helpers.
package chess_key_conditioner_pkg;

    // Consumer key polarity: a key input is asserted (ON) when low.
    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    // Key codes, also used as bit positions in the 4-bit key vectors.
    localparam logic [1:0] KEY_LEFT  = 2'd0;
    localparam logic [1:0] KEY_RIGHT = 2'd1;
    localparam logic [1:0] KEY_UP    = 2'd2;
    localparam logic [1:0] KEY_DOWN  = 2'd3;

    // Conditioner FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    // Fixed priority Left > Right > Up > Down over active-low keys.
    // Returns the winning key code; only meaningful when any key is ON.
    function automatic logic [1:0] prio_encode(input logic [3:0] keys_n);
        logic [1:0] sel;
        if (keys_n[KEY_LEFT] == ON) begin
            sel = KEY_LEFT;
        end else if (keys_n[KEY_RIGHT] == ON) begin
            sel = KEY_RIGHT;
        end else if (keys_n[KEY_UP] == ON) begin
            sel = KEY_UP;
        end else begin
            sel = KEY_DOWN;
        end
        return sel;
    endfunction

    // Active-low one-cold vector with only the given key ON.
    function automatic logic [3:0] key_pulse(input logic [1:0] key);
        logic [3:0] v;
        v      = {4{OFF}};
        v[key] = ON;
        return v;
    endfunction

endpackage

// File: rtl/chess_key_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous pin inputs. Each bit resets to
// its own idle level so downstream logic sees no spurious event at reset.
module chess_key_conditioner_sync2 #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             OutClock,
    input  logic             resetApp,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Shift raw pins through two metastability-settling stages.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            stage1_q <= RST_VAL;
            stage2_q <= RST_VAL;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/chess_key_conditioner.sv
// chess_key_conditioner: synchronises the four direction buttons and the
// lock switch, and turns each key press into one single-cycle active-low
// move request for the chess layout matrix.
// Build option: define KEY_AUTOREPEAT_EN to emit repeat pulses while a key
// is held (first repeat after REPEAT_DELAY ticks, then every REPEAT_PERIOD).
// Without it each press yields exactly one pulse.
module chess_key_conditioner
    import chess_key_conditioner_pkg::*;
#(
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_PERIOD = 2,
    parameter int CNT_WIDTH     = 4
) (
    input  logic OutClock,
    input  logic resetApp,
    input  logic KeyLeftRaw,
    input  logic KeyRightRaw,
    input  logic KeyUpRaw,
    input  logic KeyDownRaw,
    input  logic LockSwitchRaw,
    output logic KeyLeft,
    output logic KeyRight,
    output logic KeyUp,
    output logic KeyDown,
    output logic LockSwitch,
    output logic KeyActive
);

    // Reject configurations the repeat counter cannot represent.
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) || (CNT_WIDTH < 1) ||
        (REPEAT_DELAY > ((2 ** CNT_WIDTH) - 1)) ||
        (REPEAT_PERIOD > ((2 ** CNT_WIDTH) - 1))) begin : g_bad_cfg
        $error("chess_key_conditioner: invalid repeat configuration");
    end

    // Raw bus layout: [4] lock, [3:0] keys indexed by key code.
    logic [4:0] raw_s;
    logic [4:0] sync_s;
    logic [3:0] keys_n_s;
    logic       any_key_s;
    logic [1:0] sel_key_s;

    assign raw_s = {LockSwitchRaw, KeyDownRaw, KeyUpRaw, KeyRightRaw, KeyLeftRaw};

    chess_key_conditioner_sync2 #(
        .WIDTH   (5),
        .RST_VAL (5'b0_1111)
    ) u_sync (
        .OutClock (OutClock),
        .resetApp (resetApp),
        .d_i      (raw_s),
        .q_o      (sync_s)
    );

    assign keys_n_s  = sync_s[3:0];
    assign any_key_s = (keys_n_s != {4{OFF}});
    assign sel_key_s = prio_encode(keys_n_s);

    key_state_e state_q;
    logic [1:0] key_q;
    logic [3:0] key_out_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] DELAY_LD  = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LD = CNT_WIDTH'(REPEAT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Press/hold/repeat FSM; key outputs are registered one-cycle pulses.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state_q   <= IDLE;
            key_q     <= KEY_LEFT;
            key_out_q <= {4{OFF}};
            cnt_q     <= '0;
        end else begin
            key_out_q <= {4{OFF}};
            case (state_q)
                IDLE: begin
                    if (any_key_s) begin
                        key_q     <= sel_key_s;
                        key_out_q <= key_pulse(sel_key_s);
                        cnt_q     <= DELAY_LD;
                        state_q   <= DELAY;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                DELAY, REPEAT: begin
                    if (!any_key_s) begin
                        // Release: no pulse, just go back to waiting.
                        state_q   <= IDLE;
                    end else if (sel_key_s != key_q) begin
                        // Different key now wins: treat as a fresh press.
                        key_q     <= sel_key_s;
                        key_out_q <= key_pulse(sel_key_s);
                        cnt_q     <= DELAY_LD;
                        state_q   <= DELAY;
                    end else if (cnt_q <= CNT_ONE) begin
                        key_out_q <= key_pulse(key_q);
                        cnt_q     <= PERIOD_LD;
                        state_q   <= REPEAT;
                    end else begin
                        cnt_q     <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                end
            endcase
        end
    end
`else
    // Press FSM without repeat: one pulse per press, then wait for release
    // or a change of winning key.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state_q   <= IDLE;
            key_q     <= KEY_LEFT;
            key_out_q <= {4{OFF}};
        end else begin
            key_out_q <= {4{OFF}};
            case (state_q)
                IDLE: begin
                    if (any_key_s) begin
                        key_q     <= sel_key_s;
                        key_out_q <= key_pulse(sel_key_s);
                        state_q   <= DELAY;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                DELAY: begin
                    if (!any_key_s) begin
                        state_q   <= IDLE;
                    end else if (sel_key_s != key_q) begin
                        key_q     <= sel_key_s;
                        key_out_q <= key_pulse(sel_key_s);
                        state_q   <= DELAY;
                    end else begin
                        state_q   <= DELAY;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                end
            endcase
        end
    end
`endif

    assign KeyLeft    = key_out_q[KEY_LEFT];
    assign KeyRight   = key_out_q[KEY_RIGHT];
    assign KeyUp      = key_out_q[KEY_UP];
    assign KeyDown    = key_out_q[KEY_DOWN];
    assign LockSwitch = sync_s[4];
    assign KeyActive  = (state_q != IDLE);

endmodule

// File: tb/tb_chess_key_conditioner.sv
// Directed bench for chess_key_conditioner. Edge numbers count rising
// OutClock edges after reset release (first edge = 0). An input driven just
// after edge n is first sampled at edge n+1. Expectations follow the build:
// with KEY_AUTOREPEAT_EN, held keys repeat (delay 5, period 2).
module tb_chess_key_conditioner;

    logic OutClock = 1'b0;
    logic resetApp;
    logic KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw, LockSwitchRaw;
    logic KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch, KeyActive;

    int e;
    int checks = 0;
    int errors = 0;

    always #5 OutClock = ~OutClock;

    chess_key_conditioner #(
        .REPEAT_DELAY  (5),
        .REPEAT_PERIOD (2),
        .CNT_WIDTH     (4)
    ) dut (
        .OutClock      (OutClock),
        .resetApp      (resetApp),
        .KeyLeftRaw    (KeyLeftRaw),
        .KeyRightRaw   (KeyRightRaw),
        .KeyUpRaw      (KeyUpRaw),
        .KeyDownRaw    (KeyDownRaw),
        .LockSwitchRaw (LockSwitchRaw),
        .KeyLeft       (KeyLeft),
        .KeyRight      (KeyRight),
        .KeyUp         (KeyUp),
        .KeyDown       (KeyDown),
        .LockSwitch    (LockSwitch),
        .KeyActive     (KeyActive)
    );

    // Advance past the next rising edge and settle.
    task automatic adv();
        @(posedge OutClock);
        e = e + 1;
        #2;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    // exp_k = {down, up, right, left}, active-low.
    task automatic chk_keys(input string tag, input logic [3:0] exp_k, input logic exp_act);
        chk({tag, ".left"},   KeyLeft,   exp_k[0]);
        chk({tag, ".right"},  KeyRight,  exp_k[1]);
        chk({tag, ".up"},     KeyUp,     exp_k[2]);
        chk({tag, ".down"},   KeyDown,   exp_k[3]);
        chk({tag, ".active"}, KeyActive, exp_act);
    endtask

    // 1 when a key first pressed so its pulse lands at 'first' should be
    // pulsing at edge 'ed' (held through 'last').
    function automatic logic pulse_at(input int ed, input int first, input int last);
        if (ed == first) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if ((ed >= first + 5) && (ed <= last) && (((ed - first - 5) % 2) == 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic do_reset();
        KeyLeftRaw = 1'b1; KeyRightRaw = 1'b1; KeyUpRaw = 1'b1; KeyDownRaw = 1'b1;
        LockSwitchRaw = 1'b0;
        resetApp = 1'b1;
        #12;
        chk_keys("reset", 4'b1111, 1'b0);
        chk("reset.lock", LockSwitch, 1'b0);
        @(negedge OutClock);
        resetApp = 1'b0;
        e = -1;
    endtask

    initial begin
        e = -1;

        // Single key held: pulse at 12, repeats 17..29 (auto), idle at 31.
        do_reset();
        while (e < 9) adv();
        KeyLeftRaw = 1'b0;
        repeat (24) begin
            adv();
            chk_keys("hold_left", {3'b111, ~pulse_at(e, 12, 29)}, (e >= 12) && (e <= 30));
            if (e == 28) KeyLeftRaw = 1'b1;
        end

        // Up and Down together: only Up pulses.
        do_reset();
        while (e < 3) adv();
        KeyUpRaw = 1'b0; KeyDownRaw = 1'b0;
        repeat (12) begin
            adv();
            chk_keys("prio_up_down", {1'b1, ~pulse_at(e, 6, 99), 2'b11}, e >= 6);
        end

        // Down held, Left added: Left restarts the press sequence.
        do_reset();
        KeyDownRaw = 1'b0;
        repeat (15) begin
            adv();
            chk_keys("down_then_left",
                     {~pulse_at(e, 2, 2), 2'b11, ~pulse_at(e, 6, 99)}, e >= 2);
            if (e == 3) KeyLeftRaw = 1'b0;
        end

        // Reset while Right is held: immediate idle, then a fresh press.
        do_reset();
        KeyRightRaw = 1'b0;
        repeat (16) begin
            adv();
            chk_keys("hold_right", {2'b11, ~pulse_at(e, 2, 99), 1'b1}, e >= 2);
        end
        resetApp = 1'b1;
        #1;
        chk_keys("async_reset", 4'b1111, 1'b0);
        adv();
        chk_keys("in_reset", 4'b1111, 1'b0);
        @(negedge OutClock);
        resetApp = 1'b0;
        repeat (4) begin
            adv();
            chk_keys("after_reset", {2'b11, ~pulse_at(e, 19, 99), 1'b1}, e >= 19);
        end

        // Lock switch passes through with two-cycle latency.
        do_reset();
        while (e < 3) adv();
        LockSwitchRaw = 1'b1;
        repeat (4) begin
            adv();
            chk("lock", LockSwitch, e >= 5);
            chk_keys("lock_keys", 4'b1111, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
